// File: rtl/fib_datapath.sv
// Datapath for the Fibonacci sequencer: three-entry register bank, operand muxes,
// a four-function ALU with registered accumulator, and the flags polled by the control FSM.
module fib_datapath #(
  parameter int unsigned WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT0 = '0,
  parameter logic [WIDTH-1:0] INIT1 = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cnt_alu,
  input  logic [1:0]       slc_mux_a,
  input  logic [1:0]       slc_mux_b,
  input  logic [1:0]       slc_reg,
  input  logic             w,
  input  logic [WIDTH-1:0] limit,
  output logic             mayor,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] acc,
  output logic             ovf,
  output logic [7:0]       iter
);

  logic [WIDTH-1:0] r0_q, r1_q, r2_q, acc_q;
  logic [WIDTH-1:0] r0_d, r1_d, r2_d, acc_d;
  logic             mayor_q, mayor_d, ovf_q, ovf_d;
  logic [7:0]       iter_q, iter_d;

  logic [WIDTH-1:0] opA, opB;
  logic [WIDTH:0]   aluRes;
  logic             writeR2;

  always_comb begin
    opA = '0;
    case (slc_mux_a)
      2'b00:   opA = r0_q;
      2'b01:   opA = r1_q;
      2'b10:   opA = r2_q;
      default: opA = '0;
    endcase
  end

  always_comb begin
    opB = '0;
    case (slc_mux_b)
      2'b00:   opB = r0_q;
      2'b01:   opB = r1_q;
      2'b10:   opB = r2_q;
      default: opB = '0;
    endcase
  end

  // Zero-extended operands make bit WIDTH the carry on add and the borrow on subtract.
  always_comb begin
    aluRes = '0;
    case (cnt_alu)
      2'b00:   aluRes = {1'b0, opA} + {1'b0, opB};
      2'b01:   aluRes = {1'b0, opA} - {1'b0, opB};
      2'b10:   aluRes = {1'b0, opA};
      default: aluRes = {1'b0, opB};
    endcase
  end

  assign writeR2 = w && (slc_reg == 2'b10);

  // Writes take the accumulator as it stood before this edge, not the live ALU output.
  always_comb begin
    r0_d    = r0_q;
    r1_d    = r1_q;
    r2_d    = r2_q;
    mayor_d = mayor_q;
    iter_d  = iter_q;
    acc_d   = aluRes[WIDTH-1:0];
    ovf_d   = ovf_q | ((cnt_alu[1] == 1'b0) && aluRes[WIDTH]);
    if (w) begin
      case (slc_reg)
        2'b00:   r0_d = acc_q;
        2'b01:   r1_d = acc_q;
        2'b10:   r2_d = acc_q;
        default: ;
      endcase
    end
    if (writeR2) begin
      mayor_d = (acc_q > limit);
      if (iter_q != 8'hFF) iter_d = iter_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_q    <= INIT0;
      r1_q    <= INIT1;
      r2_q    <= '0;
      acc_q   <= '0;
      mayor_q <= 1'b0;
      ovf_q   <= 1'b0;
      iter_q  <= 8'd0;
    end else begin
      r0_q    <= r0_d;
      r1_q    <= r1_d;
      r2_q    <= r2_d;
      acc_q   <= acc_d;
      mayor_q <= mayor_d;
      ovf_q   <= ovf_d;
      iter_q  <= iter_d;
    end
  end

  assign mayor  = mayor_q;
  assign result = r2_q;
  assign acc    = acc_q;
  assign ovf    = ovf_q;
  assign iter   = iter_q;

endmodule

// File: tb/tb_fib_datapath.sv
// Self-checking bench for fib_datapath: a behavioural model queues the expected outputs
// for every driven cycle, and scenario checks pin the key values to fixed constants.
module tb_fib_datapath;

  logic       clk;
  logic       rst;
  logic [1:0] cnt_alu, slc_mux_a, slc_mux_b, slc_reg;
  logic       w;
  logic [7:0] limit;
  logic       mayor, ovf;
  logic [7:0] result, acc, iter;

  fib_datapath #(.WIDTH(8), .INIT0(8'd0), .INIT1(8'd1)) dut (
    .clk       (clk),
    .rst       (rst),
    .cnt_alu   (cnt_alu),
    .slc_mux_a (slc_mux_a),
    .slc_mux_b (slc_mux_b),
    .slc_reg   (slc_reg),
    .w         (w),
    .limit     (limit),
    .mayor     (mayor),
    .result    (result),
    .acc       (acc),
    .ovf       (ovf),
    .iter      (iter)
  );

  typedef struct {
    int accV;
    int resultV;
    int mayorV;
    int ovfV;
    int iterV;
  } expT;

  expT expQ[$];

  int total = 0;
  int bad   = 0;

  int mReg[3];
  int mAcc, mMayor, mOvf, mIter;
  int curLim;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, got, want, $time);
    end
  endtask

  task automatic modelReset();
    mReg[0] = 0;
    mReg[1] = 1;
    mReg[2] = 0;
    mAcc    = 0;
    mMayor  = 0;
    mOvf    = 0;
    mIter   = 0;
  endtask

  // One clock: drive controls, predict the post-edge outputs, then compare after the edge.
  task automatic applyStimulus(input int a, input int b, input int alu, input int wr, input int dst);
    int opA, opB, res, flag;
    expT e, got;
    slc_mux_a = 2'(a);
    slc_mux_b = 2'(b);
    cnt_alu   = 2'(alu);
    w         = wr[0];
    slc_reg   = 2'(dst);
    limit     = 8'(curLim);
    opA  = (a == 3) ? 0 : mReg[a];
    opB  = (b == 3) ? 0 : mReg[b];
    flag = 0;
    case (alu)
      0: begin res = opA + opB; flag = (res > 255) ? 1 : 0; end
      1: begin res = opA - opB; flag = (opA < opB) ? 1 : 0; if (res < 0) res += 256; end
      2: res = opA;
      default: res = opB;
    endcase
    res = res % 256;
    if (wr != 0 && dst != 3) begin
      mReg[dst] = mAcc;
      if (dst == 2) begin
        mMayor = (mAcc > curLim) ? 1 : 0;
        if (mIter < 255) mIter++;
      end
    end
    if (alu < 2 && flag != 0) mOvf = 1;
    mAcc = res;
    e.accV = mAcc; e.resultV = mReg[2]; e.mayorV = mMayor; e.ovfV = mOvf; e.iterV = mIter;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    if (expQ.size() == 0) begin
      checkOutput("queueEmpty", 0, 1);
    end else begin
      got = expQ.pop_front();
      checkOutput("acc",    int'(acc),    got.accV);
      checkOutput("result", int'(result), got.resultV);
      checkOutput("mayor",  int'(mayor),  got.mayorV);
      checkOutput("ovf",    int'(ovf),    got.ovfV);
      checkOutput("iter",   int'(iter),   got.iterV);
    end
  endtask

  // Two-cycle FSM step: compute into acc, then write acc while the ALU idles on pass-B of zero.
  task automatic opWrite(input int a, input int b, input int alu, input int dst);
    applyStimulus(a, b, alu, 0, 3);
    applyStimulus(3, 3, 3, 1, dst);
  endtask

  // Builds a value in R0 or R2 by shift-and-add, relying on R1 holding 1.
  task automatic loadReg(input int dst, input int value);
    opWrite(3, 3, 2, dst);
    for (int i = 7; i >= 0; i--) begin
      opWrite(dst, dst, 0, dst);
      if (((value >> i) & 1) != 0) opWrite(dst, 1, 0, dst);
    end
  endtask

  task automatic applyReset();
    #3;
    rst = 1'b1;
    #1;
    checkOutput("rstResult", int'(result), 0);
    checkOutput("rstAcc",    int'(acc),    0);
    checkOutput("rstMayor",  int'(mayor),  0);
    checkOutput("rstOvf",    int'(ovf),    0);
    checkOutput("rstIter",   int'(iter),   0);
    modelReset();
    expQ.delete();
    w = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; w = 1'b0; cnt_alu = 2'b00; slc_mux_a = 2'b00; slc_mux_b = 2'b00;
    slc_reg = 2'b11; limit = 8'd5; curLim = 5;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Disturb state, then reset asynchronously mid-cycle and read R0/R1 back through the ALU.
    opWrite(0, 1, 0, 2);
    applyStimulus(1, 1, 0, 0, 3);
    applyReset();
    applyStimulus(0, 3, 2, 0, 3);
    checkOutput("initR0", int'(acc), 0);
    applyStimulus(1, 3, 2, 0, 3);
    checkOutput("initR1", int'(acc), 1);

    // Fibonacci loop against limit 5.
    applyReset();
    curLim = 5;
    applyStimulus(0, 1, 0, 0, 3);
    checkOutput("fibAcc1", int'(acc), 1);
    applyStimulus(3, 3, 3, 1, 2);
    checkOutput("fibRes1",   int'(result), 1);
    checkOutput("fibIter1",  int'(iter),   1);
    checkOutput("fibMayor1", int'(mayor),  0);
    for (int k = 0; k < 8 && mReg[2] < 8; k++) begin
      opWrite(1, 3, 2, 0);
      opWrite(2, 3, 2, 1);
      opWrite(0, 1, 0, 2);
      if (mReg[2] == 5) checkOutput("fibMayorAt5", int'(mayor), 0);
    end
    checkOutput("fibRes8",   int'(result), 8);
    checkOutput("fibMayor8", int'(mayor),  1);
    checkOutput("fibIter5",  int'(iter),   5);

    // Limit change alone, then gated writes.
    curLim = 200;
    applyStimulus(3, 3, 3, 0, 3);
    applyStimulus(3, 3, 3, 0, 3);
    checkOutput("limitHold", int'(mayor), 1);
    applyStimulus(0, 1, 0, 1, 3);
    checkOutput("noDestRes",  int'(result), 8);
    checkOutput("noDestIter", int'(iter),   5);
    applyStimulus(3, 3, 3, 0, 2);
    checkOutput("wOffRes", int'(result), 8);
    applyStimulus(2, 3, 2, 0, 3);
    checkOutput("gatedR2", int'(acc), 8);

    // Overflow: 200 + 100 wraps to 44 with a sticky carry.
    applyReset();
    curLim = 255;
    loadReg(0, 200);
    loadReg(2, 100);
    opWrite(2, 3, 2, 1);
    opWrite(0, 1, 0, 2);
    checkOutput("ovfRes",  int'(result), 44);
    checkOutput("ovfFlag", int'(ovf),    1);
    applyStimulus(0, 3, 0, 0, 3);
    applyStimulus(1, 3, 2, 0, 3);
    checkOutput("ovfSticky", int'(ovf), 1);
    checkOutput("ovfAccR1",  int'(acc), 100);

    // Subtract and pass functions.
    applyReset();
    applyStimulus(1, 0, 1, 0, 3);
    checkOutput("sub10Acc", int'(acc), 1);
    checkOutput("sub10Ovf", int'(ovf), 0);
    applyStimulus(3, 1, 1, 0, 3);
    checkOutput("sub01Acc", int'(acc), 255);
    checkOutput("sub01Ovf", int'(ovf), 1);
    applyStimulus(1, 0, 2, 0, 3);
    checkOutput("passA", int'(acc), 1);
    applyStimulus(0, 1, 3, 0, 3);
    checkOutput("passB", int'(acc), 1);

    // Random operations cross-checked against the model.
    for (int k = 0; k < 60; k++) begin
      curLim = int'($urandom_range(0, 255));
      applyStimulus(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
                    int'($urandom_range(0, 3)));
    end

    // iter saturation.
    applyReset();
    for (int k = 0; k < 300; k++) applyStimulus(3, 3, 3, 1, 2);
    checkOutput("iterSat", int'(iter), 255);

    // Reset landing in the write cycle discards the write.
    applyReset();
    curLim = 0;
    opWrite(0, 1, 0, 2);
    applyStimulus(0, 1, 0, 0, 3);
    checkOutput("preRstAcc", int'(acc), 1);
    slc_mux_a = 2'b11; slc_mux_b = 2'b11; cnt_alu = 2'b11;
    w = 1'b1; slc_reg = 2'b10;
    applyReset();
    applyStimulus(3, 3, 3, 0, 3);
    checkOutput("midRstRes",   int'(result), 0);
    checkOutput("midRstIter",  int'(iter),   0);
    checkOutput("midRstMayor", int'(mayor),  0);
    applyStimulus(1, 3, 2, 0, 3);
    checkOutput("midRstR1", int'(acc), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
